// File: rtl/memory_access.sv
// Data-memory access stage: runs a req/gnt/rvalid bus transaction for loads and stores,
// formats load data for writeback and stalls the upstream pipeline while busy.
`timescale 1ns/1ps
module memory_access #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic              memren_i,
  input  logic              memwen_i,
  input  logic [2:0]        funct3_i,
  input  logic [AWIDTH-1:0] alu_res_i,
  input  logic [DWIDTH-1:0] rs2_data_i,
  output logic [DWIDTH-1:0] memory_data_o,
  output logic              stall_o,
  output logic              done_o,
  output logic              err_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [AWIDTH-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [DWIDTH-1:0] bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [DWIDTH-1:0] bus_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t            r_state;
  logic [AWIDTH-1:0] r_addr;
  logic [DWIDTH-1:0] r_rs2;
  logic [2:0]        r_funct3;
  logic              r_load;
  logic [DWIDTH-1:0] r_mem_data;

  logic              w_start;
  logic              w_illegal;
  logic              w_accept;
  logic [1:0]        w_a;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DWIDTH-1:0] w_load_fmt;

  assign w_start  = valid_i & (memren_i | memwen_i) & (r_state == S_IDLE);
  assign w_accept = w_start & ~w_illegal;

  // BU/HU are load-only encodings, so a store using them is rejected too
  always_comb begin
    w_illegal = 1'b1;
    case (funct3_i)
      3'b000:  w_illegal = 1'b0;
      3'b001:  w_illegal = alu_res_i[0];
      3'b010:  w_illegal = |alu_res_i[1:0];
      3'b100:  w_illegal = memwen_i;
      3'b101:  w_illegal = memwen_i | alu_res_i[0];
      default: w_illegal = 1'b1;
    endcase
  end

  assign err_o         = w_start & w_illegal;
  assign stall_o       = w_accept | (r_state == S_REQ) | (r_state == S_WAIT);
  assign done_o        = (r_state == S_DONE);
  assign bus_req_o     = (r_state == S_REQ);
  assign memory_data_o = r_mem_data;

  assign w_a = r_addr[1:0];

  always_comb begin
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_be_o    = '0;
    bus_wdata_o = '0;
    if (r_state == S_REQ) begin
      bus_we_o   = ~r_load;
      bus_addr_o = {r_addr[AWIDTH-1:2], 2'b00};
      if (r_load) begin
        bus_be_o = 4'b1111;
      end else begin
        case (r_funct3[1:0])
          2'b00: begin
            bus_be_o    = 4'b0001 << w_a;
            bus_wdata_o = {4{r_rs2[7:0]}};
          end
          2'b01: begin
            bus_be_o    = 4'b0011 << w_a;
            bus_wdata_o = {2{r_rs2[15:0]}};
          end
          default: begin
            bus_be_o    = 4'b1111;
            bus_wdata_o = r_rs2;
          end
        endcase
      end
    end
  end

  assign w_byte = 8'(bus_rdata_i >> {w_a, 3'b000});
  assign w_half = 16'(bus_rdata_i >> {w_a[1], 4'b0000});

  always_comb begin
    case (r_funct3)
      3'b000:  w_load_fmt = {{(DWIDTH-8){w_byte[7]}}, w_byte};
      3'b001:  w_load_fmt = {{(DWIDTH-16){w_half[15]}}, w_half};
      3'b100:  w_load_fmt = {{(DWIDTH-8){1'b0}}, w_byte};
      3'b101:  w_load_fmt = {{(DWIDTH-16){1'b0}}, w_half};
      default: w_load_fmt = bus_rdata_i;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_rs2      <= '0;
      r_funct3   <= '0;
      r_load     <= 1'b0;
      r_mem_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_addr   <= alu_res_i;
          r_rs2    <= rs2_data_i;
          r_funct3 <= funct3_i;
          r_load   <= memren_i;
          r_state  <= S_REQ;
        end
        S_REQ: if (bus_gnt_i) r_state <= r_load ? S_WAIT : S_DONE;
        S_WAIT: if (bus_rvalid_i) begin
          r_mem_data <= w_load_fmt;
          r_state    <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Randomized scoreboard bench for memory_access: the driver pushes expected bus
// requests and load results, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_memory_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i, memren_i, memwen_i;
  logic [2:0]  funct3_i;
  logic [31:0] alu_res_i, rs2_data_i;
  logic [31:0] memory_data_o;
  logic        stall_o, done_o, err_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i, bus_rvalid_i;
  logic [31:0] bus_rdata_i;

  memory_access #(.DWIDTH(32), .AWIDTH(32)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .memren_i(memren_i),
    .memwen_i(memwen_i), .funct3_i(funct3_i), .alu_res_i(alu_res_i),
    .rs2_data_i(rs2_data_i), .memory_data_o(memory_data_o), .stall_o(stall_o),
    .done_o(done_o), .err_o(err_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] mem;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  bit          exp_stall = 0;
  bit          exp_done  = 0;
  logic [31:0] exp_mem   = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference rules for legality, store lanes and load extension
  function automatic bit legal_f(input bit st, input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'd0:    return 1;
      3'd1:    return (a % 2) == 0;
      3'd2:    return (a % 4) == 0;
      3'd4:    return !st;
      3'd5:    return !st && (a % 2) == 0;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] load_f(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * (a % 4))) & 32'hFF;
    h = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return rd;
    endcase
  endfunction

  task automatic op(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] rs2, input logic [31:0] rdata,
                    input int unsigned gd, input int unsigned rd);
    exp_t e;
    bit   legal;
    valid_i    = 1'b1;
    memren_i   = ld;
    memwen_i   = st;
    funct3_i   = f3;
    alu_res_i  = addr;
    rs2_data_i = rs2;
    if (!ld && !st) begin
      exp_stall = 0;
      step();
      valid_i = 1'b0;
      return;
    end
    legal   = legal_f(st, f3, addr);
    e.is_err = !legal;
    e.we     = st;
    e.addr   = addr & 32'hFFFF_FFFC;
    if (ld) begin
      e.be    = 4'hF;
      e.wdata = '0;
    end else if (f3 == 3'd0) begin
      e.be    = 4'(1 << (addr % 4));
      e.wdata = (rs2 & 32'hFF) * 32'h0101_0101;
    end else if (f3 == 3'd1) begin
      e.be    = 4'(3 << (addr % 4));
      e.wdata = (rs2 & 32'hFFFF) * 32'h0001_0001;
    end else begin
      e.be    = 4'hF;
      e.wdata = rs2;
    end
    if (legal && ld) exp_mem = load_f(f3, addr, rdata);
    e.mem = exp_mem;
    sb.push_back(e);
    exp_stall = legal;
    step();
    if (!legal) begin
      valid_i   = 1'b0;
      exp_stall = 0;
      return;
    end
    // REQ: upstream keeps presenting junk that must be ignored
    memren_i  = 1'b1;
    memwen_i  = 1'b0;
    funct3_i  = 3'($urandom);
    alu_res_i = $urandom;
    for (int unsigned i = 0; i < gd; i++) begin
      bus_gnt_i    = 1'b0;
      bus_rvalid_i = 1'($urandom);
      bus_rdata_i  = $urandom;
      step();
    end
    bus_gnt_i    = 1'b1;
    bus_rvalid_i = 1'($urandom);
    bus_rdata_i  = $urandom;
    step();
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b0;
    if (ld) begin
      for (int unsigned i = 0; i < rd; i++) step();
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = rdata;
      step();
      bus_rvalid_i = 1'b0;
      bus_rdata_i  = $urandom;
    end
    exp_stall = 0;
    exp_done  = 1;
    step();
    exp_done = 0;
    valid_i  = 1'b0;
    memren_i = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    bit   exp_err;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("stall", stall_o, exp_stall);
        chk("done", done_o, exp_done);
        exp_err = (sb.size() > 0) && sb[0].is_err;
        chk("err", err_o, exp_err);
        if (exp_err) begin
          void'(sb.pop_front());
          chk("err_no_req", bus_req_o, 0);
        end
        if (bus_req_o) begin
          if (sb.size() > 0 && !sb[0].is_err) begin
            chk("bus_addr", bus_addr_o, sb[0].addr);
            chk("bus_be", bus_be_o, sb[0].be);
            chk("bus_we", bus_we_o, sb[0].we);
            chk("bus_wdata", bus_wdata_o, sb[0].wdata);
          end else begin
            chk("req_unexpected", bus_req_o, 0);
          end
        end
        if (exp_done && sb.size() > 0) begin
          e = sb.pop_front();
          chk("mem_data", memory_data_o, e.mem);
        end
      end
    end
  end

  task automatic reset_in_wait();
    exp_t e;
    e.is_err = 0; e.we = 0; e.addr = 32'h200; e.be = 4'hF; e.wdata = '0; e.mem = exp_mem;
    sb.push_back(e);
    valid_i = 1'b1; memren_i = 1'b1; memwen_i = 1'b0; funct3_i = 3'd2; alu_res_i = 32'h200;
    exp_stall = 1;
    step();
    valid_i   = 1'b0;
    bus_gnt_i = 1'b1;
    step();
    bus_gnt_i = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("rst_req", bus_req_o, 0);
    chk("rst_we", bus_we_o, 0);
    chk("rst_addr", bus_addr_o, 0);
    chk("rst_be", bus_be_o, 0);
    chk("rst_wdata", bus_wdata_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_mem", memory_data_o, 0);
    sb.delete();
    exp_mem = '0; exp_stall = 0; exp_done = 0;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'hCAFE_F00D;
    step();
    reset = 1'b0;
    step();
    bus_rvalid_i = 1'b0;
    chk("rst_spurious_mem", memory_data_o, 0);
    chk("rst_spurious_stall", stall_o, 0);
  endtask

  initial begin : driver
    logic [2:0] legal_f3 [5];
    logic [2:0] f3;
    bit         ld;
    legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    reset = 1'b1;
    valid_i = 0; memren_i = 0; memwen_i = 0; funct3_i = '0;
    alu_res_i = '0; rs2_data_i = '0;
    bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = '0;
    #1;
    chk("init_mem", memory_data_o, 0);
    chk("init_req", bus_req_o, 0);
    chk("init_stall", stall_o, 0);
    step();
    step();
    reset = 1'b0;
    step();

    op(1, 0, 3'd2, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0);
    op(1, 0, 3'd0, 32'h103, 32'h0, 32'h80FF_0000, 0, 0);
    op(1, 0, 3'd4, 32'h103, 32'h0, 32'h80FF_0000, 0, 0);
    op(1, 0, 3'd1, 32'h102, 32'h0, 32'h80FF_0000, 1, 0);
    op(1, 0, 3'd5, 32'h102, 32'h0, 32'h80FF_0000, 0, 1);
    op(0, 1, 3'd0, 32'h101, 32'h1234_5678, 32'h0, 0, 0);
    op(0, 1, 3'd1, 32'h102, 32'h1234_5678, 32'h0, 2, 0);
    op(0, 1, 3'd2, 32'h104, 32'h1234_5678, 32'h0, 0, 0);
    op(1, 0, 3'd2, 32'h102, 32'h0, 32'h1111_1111, 0, 0);
    op(0, 1, 3'd1, 32'h101, 32'h0, 32'h0, 0, 0);
    op(0, 1, 3'd4, 32'h100, 32'h0, 32'h0, 0, 0);
    op(1, 0, 3'd3, 32'h100, 32'h0, 32'h0, 0, 0);
    op(1, 0, 3'd2, 32'h300, 32'h0, 32'h0BAD_CAFE, 3, 2);
    op(0, 0, 3'd2, 32'h300, 32'h0, 32'h0, 0, 0);

    reset_in_wait();
    op(1, 0, 3'd2, 32'h100, 32'h0, 32'h1357_9BDF, 0, 0);

    for (int unsigned n = 0; n < 250; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        op(0, 0, 3'($urandom), $urandom, $urandom, $urandom, 0, 0);
      end else begin
        ld = 1'($urandom);
        f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : legal_f3[$urandom_range(0, 4)];
        op(ld, !ld, f3, $urandom, $urandom, $urandom,
           $urandom_range(0, 3), $urandom_range(0, 3));
      end
    end

    step();
    step();
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
